// File: rtl/gp_regfile_select_encode.sv
// gp_regfile_select_encode
// Register-field select/decode for the datapath bus plus the general-purpose
// register file. The IR register fields chosen by gra/grb/grc are ORed into one
// register index, decoded to one-hot write/drive strobes, and the selected
// register latches bus_mux_out. R0 reads as zero on the bus side while baout is
// high, which gives base-address-plus-offset addressing without a dedicated zero
// register. csign sign-extends the IR immediate field for the bus mux.
module gp_regfile_select_encode #(
    parameter int DATA_W  = 32,
    parameter int NREG    = 16,
    parameter int FIELD_W = 4,
    parameter int CSIGN_W = 19
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        bus_mux_out,
    input  logic [DATA_W-1:0]        ir,
    input  logic                     gra,
    input  logic                     grb,
    input  logic                     grc,
    input  logic                     rin,
    input  logic                     rout,
    input  logic                     baout,
    output logic [NREG-1:0]          rin_onehot,
    output logic [NREG-1:0]          rout_onehot,
    output logic [NREG*DATA_W-1:0]   regs_flat,
    output logic [DATA_W-1:0]        csign
);

    // IR field positions: Ra sits just below bit 27, Rb and Rc follow downward.
    localparam int RA_LSB = 27 - FIELD_W;
    localparam int RB_LSB = RA_LSB - FIELD_W;
    localparam int RC_LSB = RB_LSB - FIELD_W;

    logic [FIELD_W-1:0] sel_s;
    logic [NREG-1:0]    dec_s;
    logic [DATA_W-1:0]  regs_q [NREG];
    logic [DATA_W-1:0]  regs_d [NREG];

    // The opcode bits above Ra are not used by this block.
    logic unused_ir_s;
    assign unused_ir_s = ^ir[DATA_W-1:27];

    // Merge the enabled register fields; several enables OR together with no priority.
    always_comb begin
        sel_s = {FIELD_W{1'b0}};
        sel_s = ({FIELD_W{gra}} & ir[RA_LSB +: FIELD_W])
              | ({FIELD_W{grb}} & ir[RB_LSB +: FIELD_W])
              | ({FIELD_W{grc}} & ir[RC_LSB +: FIELD_W]);
    end

    // Decode the merged index to one-hot and gate it by the write/drive strobes.
    always_comb begin
        dec_s = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            dec_s[i] = (sel_s == FIELD_W'(i));
        end
        rin_onehot  = dec_s & {NREG{rin}};
        rout_onehot = dec_s & {NREG{rout | baout}};
    end

    // Next register contents: only the decoded register loads the bus value.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (rin_onehot[i]) begin
                regs_d[i] = bus_mux_out;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Register file state; clear takes precedence over any write on the same edge.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Flatten register values for the bus mux; R0 reads as zero while baout drives.
    always_comb begin
        regs_flat = {(NREG*DATA_W){1'b0}};
        for (int i = 0; i < NREG; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
        regs_flat[DATA_W-1:0] = baout ? {DATA_W{1'b0}} : regs_q[0];
    end

    // Sign-extend the IR immediate field onto csign.
    always_comb begin
        csign = {DATA_W{1'b0}};
        csign = {{(DATA_W-CSIGN_W){ir[CSIGN_W-1]}}, ir[CSIGN_W-1:0]};
    end

endmodule

// File: tb/tb_gp_regfile_select_encode.sv
// Scoreboard bench for gp_regfile_select_encode: the driver applies one input set
// per cycle, pushes the expected combinational outputs computed from a plain
// register-array model, and a monitor on the falling edge pops and compares.
module tb_gp_regfile_select_encode;

    logic         clock;
    logic         clear;
    logic [31:0]  bus_mux_out;
    logic [31:0]  ir;
    logic         gra, grb, grc, rin, rout, baout;
    logic [15:0]  rin_onehot, rout_onehot;
    logic [511:0] regs_flat;
    logic [31:0]  csign;

    gp_regfile_select_encode dut (
        .clock       (clock),
        .clear       (clear),
        .bus_mux_out (bus_mux_out),
        .ir          (ir),
        .gra         (gra),
        .grb         (grb),
        .grc         (grc),
        .rin         (rin),
        .rout        (rout),
        .baout       (baout),
        .rin_onehot  (rin_onehot),
        .rout_onehot (rout_onehot),
        .regs_flat   (regs_flat),
        .csign       (csign)
    );

    typedef struct packed {
        logic [15:0]  rin_oh;
        logic [15:0]  rout_oh;
        logic [511:0] regs;
        logic [31:0]  cs;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_regs [16];
    int          checks = 0;
    int          errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply one cycle of inputs, predict outputs, then advance the model past the edge.
    task automatic cyc(input logic c, input logic [31:0] bus, input logic [31:0] irv,
                       input logic a, input logic b, input logic cc,
                       input logic ri, input logic ro, input logic ba);
        int   idx;
        exp_t e;
        clear = c; bus_mux_out = bus; ir = irv;
        gra = a; grb = b; grc = cc; rin = ri; rout = ro; baout = ba;
        idx = 0;
        if (a)  idx = idx | int'(irv[26:23]);
        if (b)  idx = idx | int'(irv[22:19]);
        if (cc) idx = idx | int'(irv[18:15]);
        e.rin_oh  = ri ? (16'd1 << idx) : 16'd0;
        e.rout_oh = (ro || ba) ? (16'd1 << idx) : 16'd0;
        for (int n = 0; n < 16; n++) e.regs[n*32 +: 32] = model_regs[n];
        if (ba) e.regs[31:0] = 32'd0;
        e.cs = 32'($signed(irv[18:0]));
        exp_q.push_back(e);
        if (c) begin
            for (int n = 0; n < 16; n++) model_regs[n] = 32'd0;
        end else if (ri) begin
            model_regs[idx] = bus;
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest prediction, away from the clock edge.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rin_onehot !== e.rin_oh) begin
                errors++;
                $display("FAIL rin_onehot got %h expected %h", rin_onehot, e.rin_oh);
            end
            checks++;
            if (rout_onehot !== e.rout_oh) begin
                errors++;
                $display("FAIL rout_onehot got %h expected %h", rout_onehot, e.rout_oh);
            end
            checks++;
            if (regs_flat !== e.regs) begin
                errors++;
                for (int n = 0; n < 16; n++)
                    if (regs_flat[n*32 +: 32] !== e.regs[n*32 +: 32])
                        $display("FAIL regs_flat R%0d got %h expected %h",
                                 n, regs_flat[n*32 +: 32], e.regs[n*32 +: 32]);
            end
            checks++;
            if (csign !== e.cs) begin
                errors++;
                $display("FAIL csign got %h expected %h", csign, e.cs);
            end
        end
    end

    initial begin
        int wait_cycles;
        // Initial clear to bring the DUT to a known state before scoreboarding.
        clear = 1'b1; bus_mux_out = 32'd0; ir = 32'd0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0; baout = 1'b0;
        for (int n = 0; n < 16; n++) model_regs[n] = 32'd0;
        @(posedge clock);
        #1;

        // Reset state with idle inputs.
        cyc(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Write R5 via Ra.
        cyc(1'b0, 32'hDEADBEEF, 32'd5 << 23, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Ra=1 | Rb=2 -> R3.
        cyc(1'b0, 32'h000000A5, (32'd1 << 23) | (32'd2 << 19), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // Preload R0 (no gr* -> index 0), then baout masks it, then unmasked.
        cyc(1'b0, 32'h00001234, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Write R0 while baout high: stored value still updates.
        cyc(1'b0, 32'h0BADF00D, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // csign boundaries.
        cyc(1'b0, 32'd0, 32'h00040000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 32'h0003FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // clear beats a simultaneous write to R7.
        cyc(1'b0, 32'h77777777, 32'd7 << 23, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFFFFFFF, 32'd7 << 23, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Rc path into R15.
        cyc(1'b0, 32'hCAFEF00D, 32'd15 << 15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0, $urandom, $urandom,
                1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bounded drain of outstanding predictions.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clock);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
